// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx_pkg
//  Purpose  : Shared constants and types for the memory-mapped UART
//             transmitter: register offsets, STATUS bit positions,
//             serializer state encoding and divisor clamp helper.
//  Revision : 1.0  initial release
// ============================================================================
package mmio_uart_tx_pkg;

    // Word offsets within the 16-byte register window (addr_in[3:2])
    localparam logic [1:0] c_OFF_DATA   = 2'd0;
    localparam logic [1:0] c_OFF_STATUS = 2'd1;
    localparam logic [1:0] c_OFF_CTRL   = 2'd2;

    // STATUS register bit positions
    localparam int c_ST_BUSY  = 0;
    localparam int c_ST_FULL  = 1;
    localparam int c_ST_EMPTY = 2;
    localparam int c_ST_OVF   = 3;

    // Smallest legal clocks-per-bit divisor
    localparam logic [15:0] c_MIN_DIV = 16'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Software may write any divisor; values below the minimum are raised.
    function automatic logic [15:0] clamp_div(input logic [15:0] i_div);
        return (i_div < c_MIN_DIV) ? c_MIN_DIV : i_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx_if
//  Purpose  : CPU data-memory bus bundle (ce/we/addr/sel/data).
//  Ports    : ce      - access valid
//             we      - 1 = write, 0 = read
//             addr_in - byte address
//             sel     - byte enables
//             data_i  - write data (master -> slave)
//             data_o  - read data  (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface mmio_uart_tx_if;
    logic        ce;
    logic        we;
    logic [31:0] addr_in;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output ce, we, addr_in, sel, data_i, input data_o);
    modport slave  (input ce, we, addr_in, sel, data_i, output data_o);
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : 8-bit synchronous FIFO, DEPTH entries (power of two, >= 2).
//             Show-ahead: o_dout is valid whenever o_empty is low.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             i_push     - write i_din (accepted when not full, or when full
//                          and a pop happens in the same cycle)
//             i_pop      - discard head entry (ignored when empty)
//             o_dout     - head entry
//             o_full     - DEPTH entries held
//             o_empty    - no entries held
//             o_count    - occupancy 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [7:0]               i_din,
    input  wire logic                     i_pop,
    output logic      [7:0]               o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_full;
    logic        w_empty;
    logic        w_push_ok;
    logic        w_pop_ok;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop & ~w_empty;
    // When full, a simultaneous pop frees the head slot, so the push fits.
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only pointer state defines validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter with TX FIFO and a
//             TX-drained level interrupt.
//  Ports    : clk    - system clock
//             rst    - synchronous reset, active-high
//             bus    - CPU data-memory bus (slave modport)
//             txd    - serial output, idle high
//             irq_o  - registered IE & EMPTY & ~BUSY
//  Registers: 0x0 DATA   (W)  push data_i[7:0]
//             0x4 STATUS (RW) {cnt[7:4], OVF, EMPTY, FULL, BUSY}; W1C OVF
//             0x8 CTRL   (RW) {IE[31], DIV[15:0]}
//  Revision : 1.0  initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mmio_uart_tx_if.slave       bus,
    output logic                txd,
    output logic                irq_o
);
    import mmio_uart_tx_pkg::*;

    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_push;

    assign w_hit  = bus.ce && (bus.addr_in[31:4] == BASE_ADDR[31:4]);
    assign w_off  = bus.addr_in[3:2];
    assign w_wr   = w_hit && bus.we && (bus.sel != 4'b0000);
    assign w_push = w_wr && (w_off == c_OFF_DATA);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]      w_fifo_dout;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_CW-1:0] w_fifo_count;
    logic            w_pop;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (bus.data_i[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    logic [15:0] r_div;
    logic        r_ie;
    logic        r_ovf;
    logic        r_irq;
    logic        w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DEFAULT_DIV;
            r_ie  <= 1'b0;
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && (w_off == c_OFF_CTRL)) begin
                r_div <= clamp_div(bus.data_i[15:0]);
                r_ie  <= bus.data_i[31];
            end
            // A push is lost only if full and no pop frees a slot this cycle.
            if (w_push && w_fifo_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_off == c_OFF_STATUS) && bus.data_i[c_ST_OVF])
                r_ovf <= 1'b0;
            r_irq <= r_ie & w_fifo_empty & ~w_busy;
        end
    end

    assign irq_o = r_irq;

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [15:0] r_cur_div;
    logic [15:0] w_cur_div_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic        w_cnt_done;
    logic        w_txd;

    assign w_busy     = (r_state != S_IDLE);
    assign w_cnt_done = (r_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'h00;
            r_cur_div <= DEFAULT_DIV;
            r_cnt     <= 16'd0;
            r_idx     <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cur_div <= w_cur_div_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

    // r_cnt counts down the remaining cycles of the current bit; each bit
    // lasts r_cur_div cycles because the count is reloaded with div-1.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cur_div_nxt = r_cur_div;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_pop         = 1'b0;
        w_txd         = 1'b1;
        case (r_state)
            S_IDLE: begin
                // Divisor is latched here so mid-frame CTRL writes only
                // affect the next frame.
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_fifo_dout;
                    w_cur_div_nxt = r_div;
                    w_cnt_nxt     = r_div - 16'd1;
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_cnt_done) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = r_cur_div - 16'd1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_cnt_done) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_cnt_nxt   = r_cur_div - 16'd1;
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                    else               w_idx_nxt   = r_idx + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_STOP: begin
                w_txd = 1'b1;
                if (w_cnt_done) w_state_nxt = S_IDLE;
                else            w_cnt_nxt   = r_cnt - 16'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign txd = w_txd;

    // ------------------------------------------------------------------
    // Read mux: combinational, side-effect free
    // ------------------------------------------------------------------
    logic [31:0] w_count32;
    logic [3:0]  w_cnt_sat;
    logic [31:0] w_rdata;

    assign w_count32 = 32'(w_fifo_count);
    assign w_cnt_sat = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];

    always_comb begin
        w_rdata = 32'h0;
        if (w_hit && !bus.we) begin
            case (w_off)
                c_OFF_STATUS: w_rdata = {24'h0, w_cnt_sat, r_ovf, w_fifo_empty,
                                         w_fifo_full, w_busy};
                c_OFF_CTRL:   w_rdata = {r_ie, 15'h0, r_div};
                default:      w_rdata = 32'h0;
            endcase
        end
    end

    assign bus.data_o = w_rdata;

    // Address byte-lane bits and reserved CTRL bits carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, bus.addr_in[1:0], bus.data_i[30:16]};

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_uart_tx
//  Purpose  : Self-checking bench for mmio_uart_tx. Stimulus pushes the
//             expected frames (byte + divisor) into a queue; an independent
//             line monitor decodes txd and compares against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'd4;
    localparam logic [31:0] A_CTRL   = BASE + 32'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;
    logic irq_o;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .txd   (txd),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int     start_q[$];
    int     checks    = 0;
    int     errors    = 0;
    int     cyc       = 0;
    int     model_div = 868;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Line monitor: every frame is 10*div cycles: start 0, 8 data LSB
    // first, stop 1. Reset discards in-flight and queued frames.
    // ------------------------------------------------------------------
    int     mon_pos  = -1;
    int     mon_bitn;
    int     mon_bad;
    bit     mon_junk = 1'b0;
    bit     mon_ok;
    logic   mon_exp;
    logic   mon_act;
    frame_t mon_cur;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_pos  = -1;
            mon_junk = 1'b0;
            exp_q.delete();
        end else if (mon_junk) begin
            if (txd === 1'b1) mon_junk = 1'b0;
        end else begin
            if (mon_pos < 0 && txd !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame txd=%b at cycle %0d with nothing queued", txd, cyc);
                    mon_junk = 1'b1;
                end else begin
                    mon_cur = exp_q.pop_front();
                    start_q.push_back(cyc);
                    mon_pos = 0;
                    mon_ok  = 1'b1;
                end
            end
            if (mon_pos >= 0) begin
                mon_bitn = mon_pos / mon_cur.div;
                if (mon_bitn == 0)      mon_exp = 1'b0;
                else if (mon_bitn == 9) mon_exp = 1'b1;
                else                    mon_exp = mon_cur.data[mon_bitn-1];
                if (txd !== mon_exp && mon_ok) begin
                    mon_ok  = 1'b0;
                    mon_bad = mon_pos;
                    mon_act = txd;
                end
                mon_pos++;
                if (mon_pos == 10 * mon_cur.div) begin
                    checks++;
                    if (!mon_ok) begin
                        errors++;
                        $display("FAIL frame byte=%h div=%0d first bad cycle %0d actual=%b expected=%b",
                                 mon_cur.data, mon_cur.div, mon_bad, mon_act, ~mon_act);
                    end
                    mon_pos = -1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus tasks: called at posedge+1, return at the next posedge+1
    // ------------------------------------------------------------------
    task automatic bus_cycle(input logic c, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             output logic [31:0] rd_val);
        bus.ce      = c;
        bus.we      = w;
        bus.addr_in = a;
        bus.sel     = s;
        bus.data_i  = d;
        #1;
        rd_val = bus.data_o;
        @(posedge clk);
        #1;
        bus.ce  = 1'b0;
        bus.we  = 1'b0;
        bus.sel = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        logic [15:0] dv;
        bus_cycle(1'b1, 1'b1, a, 4'hF, d, dummy);
        if (a == A_CTRL) begin
            dv = d[15:0];
            model_div = (dv < 16'd2) ? 2 : int'(dv);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus_cycle(1'b1, 1'b0, a, 4'h0, 32'h0, v);
    endtask

    task automatic push(input logic [7:0] b, input int div, input bit accepted);
        wr(A_DATA, {24'h0, b});
        if (accepted) exp_q.push_back('{b, div});
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] st;
        int n;
        n = 0;
        do begin
            rd(A_STATUS, st);
            n++;
        end while (!(st[2] == 1'b1 && st[0] == 1'b0) && n < 5000);
        check({name, "_idle_status"}, st, 32'h4);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_div = 868;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        int          k;
        int          n;
        int          gap;

        bus.ce = 1'b0; bus.we = 1'b0; bus.addr_in = 32'h0; bus.sel = 4'h0; bus.data_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_txd", {31'h0, txd}, 32'h1);
        check("reset_irq", {31'h0, irq_o}, 32'h0);
        rd(A_STATUS, v); check("reset_status", v, 32'h4);
        rd(A_CTRL, v);   check("reset_ctrl", v, 32'd868);

        // Single frame 0xA5 at DIV=4; head is not bypassed to the serializer
        wr(A_CTRL, 32'h0000_0004);
        push(8'hA5, model_div, 1'b1);
        rd(A_STATUS, v); check("status_after_push", v, 32'h10);
        rd(A_STATUS, v); check("status_busy", v, 32'h5);
        wait_idle("a5");

        // 17 back-to-back pushes at DIV=2: one leaves for the shift register
        // after the first push, so all 17 fit and the FIFO ends full.
        wr(A_CTRL, 32'h0000_0002);
        for (int i = 0; i < 17; i++) push(8'($urandom), model_div, 1'b1);
        rd(A_STATUS, v); check("status_17_full", v, 32'hF3);
        wait_idle("burst17");

        // Stalled serializer: DEPTH in FIFO + 1 in shift register accepted
        wr(A_CTRL, 32'h0000_FFFF);
        for (int i = 0; i < 18; i++) push(8'($urandom), model_div, (i < DEPTH + 1));
        rd(A_STATUS, v); check("status_overflow", v, 32'hFB);
        wr(A_STATUS, 32'h0000_0008);
        rd(A_STATUS, v); check("status_ovf_cleared", v, 32'hF3);
        pulse_reset();
        check("ovf_reset_txd", {31'h0, txd}, 32'h1);
        rd(A_STATUS, v); check("ovf_reset_status", v, 32'h4);

        // Back-to-back frames at DIV=3: 30 cycles each plus one idle cycle
        wr(A_CTRL, 32'h0000_0003);
        start_q.delete();
        push(8'h00, model_div, 1'b1);
        push(8'hFF, model_div, 1'b1);
        wait_idle("b2b");
        gap = (start_q.size() == 2) ? (start_q[1] - start_q[0]) : -1;
        check("b2b_start_gap", gap, 31);

        // Interrupt: high when idle+empty, low while busy, rises 10*div+2
        // cycles after the push edge (1 pop delay, frame, 1 register stage).
        wr(A_CTRL, 32'h8000_0002);
        rd(A_CTRL, v); check("ctrl_ie_readback", v, 32'h8000_0002);
        check("irq_idle_empty", {31'h0, irq_o}, 32'h1);
        push(8'h3C, model_div, 1'b1);
        @(posedge clk); #1;
        check("irq_low_busy", {31'h0, irq_o}, 32'h0);
        k = 1;
        while (irq_o !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("irq_rise_cycle", k, 10 * 2 + 2);
        push(8'hC3, model_div, 1'b1);
        @(posedge clk); #1;
        check("irq_drop_on_push", {31'h0, irq_o}, 32'h0);
        wait_idle("irq");

        // DIV=0 clamps to 2, IE cleared
        wr(A_CTRL, 32'h0000_0000);
        rd(A_CTRL, v); check("ctrl_div_clamp", v, 32'h2);

        // Mid-frame DIV write only affects the following frame
        push(8'h96, model_div, 1'b1);
        push(8'h4B, 5, 1'b1);
        wr(A_CTRL, 32'h0000_0005);
        wait_idle("middiv");

        // Ignored accesses
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rd(BASE + 32'hC, v);  check("off3_read", v, 32'h0);
        wr(BASE + 32'h10, 32'h0000_0055);
        rd(BASE + 32'h18, v); check("outside_read", v, 32'h0);
        bus_cycle(1'b0, 1'b1, A_DATA, 4'hF, 32'h77, v);
        bus_cycle(1'b0, 1'b0, A_CTRL, 4'h0, 32'h0, v); check("ce0_read", v, 32'h0);
        bus_cycle(1'b1, 1'b1, A_CTRL, 4'h0, 32'h8000_0009, v); check("write_cycle_read", v, 32'h0);
        rd(A_DATA, v); check("data_read", v, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rd(A_STATUS, v); check("ignored_status", v, 32'h4);
        rd(A_CTRL, v);   check("ignored_ctrl", v, 32'h5);

        // Reset during data bit 3 at DIV=8 (push edge + 1 pop + 8 start + 24)
        wr(A_CTRL, 32'h8000_0008);
        push(8'($urandom), model_div, 1'b1);
        repeat (35) @(posedge clk);
        #1;
        pulse_reset();
        check("midrst_txd", {31'h0, txd}, 32'h1);
        check("midrst_irq", {31'h0, irq_o}, 32'h0);
        rd(A_STATUS, v); check("midrst_status", v, 32'h4);
        rd(A_CTRL, v);   check("midrst_ctrl", v, 32'd868);

        // Randomized frames
        for (int it = 0; it < 6; it++) begin
            wr(A_CTRL, 32'($urandom_range(0, 6)));
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                push(b, model_div, 1'b1);
            end
            wait_idle("random");
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
